// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: read-side drain stage for the async FIFO (clk_rd domain).
// Issues credit-limited FIFO reads and captures the registered read data one
// cycle later into a small skid buffer. The buffer is presented downstream as
// a valid/ready stream.
// Optional build macro RD_STREAM_CNT_EN adds a handshake counter (cnt_clr/xfer_cnt).
module afifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                clk_rd,
  input  logic                                rst_rd_n,
  input  logic                                fifo_empty,
  output logic                                fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]               fifo_rdata,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
`ifdef RD_STREAM_CNT_EN
  input  logic                                cnt_clr,
  output logic [CNT_WIDTH-1:0]                xfer_cnt,
`endif
  output logic [$clog2(SKID_DEPTH+1)-1:0]     buf_level
);

  localparam int IDX_W = $clog2(SKID_DEPTH);
  localparam int LVL_W = $clog2(SKID_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  inflight_q, inflight_d;

  logic [LVL_W:0]        used_s;
  logic                  rd_en_s;
  logic                  push_s;
  logic                  pop_s;

  // Credit check: words held plus the one in flight must leave room for a new
  // read. Only fifo_empty and local state feed the strobe, never m_ready. The
  // reset term keeps the strobe low while reset is held.
  always_comb begin
    used_s  = {1'b0, level_q} + {{LVL_W{1'b0}}, inflight_q};
    rd_en_s = rst_rd_n & ~fifo_empty & (used_s < (LVL_W+1)'(SKID_DEPTH));
    push_s  = inflight_q;
    pop_s   = (level_q != {LVL_W{1'b0}}) & m_ready;
  end

  // Next-state for indices, fill level and the in-flight marker.
  always_comb begin
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    level_d    = level_q;
    inflight_d = rd_en_s;
    if (push_s) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (pop_s) begin
      rd_idx_d = rd_idx_q + IDX_W'(1);
    end else begin
      rd_idx_d = rd_idx_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state registers; reset drops any read that is still in flight.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      wr_idx_q   <= {IDX_W{1'b0}};
      rd_idx_q   <= {IDX_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
    end
  end

  // Skid storage: capture the FIFO read data on the edge after an issued read.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_idx_q] <= fifo_rdata;
    end
  end

`ifdef RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Handshake counter next state; clear wins over a same-cycle handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (pop_s) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Handshake counter register.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = (level_q != {LVL_W{1'b0}});
  assign m_data     = mem_q[rd_idx_q];
  assign buf_level  = level_q;

endmodule

// File: doc/afifo_rd_stream.md
Name: afifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of the async FIFO, in the clk_rd domain.
- Issues FIFO read strobes, captures the FIFO's registered read data one cycle later, and buffers it in a small skid buffer.
- Presents the data as a valid/ready stream, so consumers never deal with FIFO read latency or the empty flag.
- Single clock, no CDC inside this block.

Parameters:
- DATA_WIDTH, 32, width of FIFO data and stream data.
- SKID_DEPTH, 4, skid buffer entries; power of 2, minimum 2. Values of 3 or more are required for 1 word/cycle throughput.
- CNT_WIDTH, 16, width of the transfer counter (used only with RD_STREAM_CNT_EN).

Ports:
- clk_rd  in  1  read-domain clock.
- rst_rd_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag in the clk_rd domain. It is the same flag that gates the FIFO's internal read.
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after an honoured fifo_rd_en.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_WIDTH  stream data (head of the skid buffer).
- buf_level  out  $clog2(SKID_DEPTH+1)  number of words currently held in the skid buffer.

Interface note: one clock (clk_rd); reset rst_rd_n is asynchronous and active-low.

Behaviour:
- Reset (asynchronous, rst_rd_n=0):
  - Outputs: fifo_rd_en=0, m_valid=0, m_data=0, buf_level=0.
  - Internal state cleared: write/read indices, inflight flag.
  - A read in flight when reset asserts is discarded; its data is never captured.
- Read issue:
  - fifo_rd_en = ~fifo_empty && (buf_level + inflight) < SKID_DEPTH.
  - No combinational path from m_ready to fifo_rd_en.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Inflight flag:
  - Set on the edge where fifo_rd_en=1.
  - Cleared on the next edge, where fifo_rdata is written into the buffer at the write index.
  - Read latency is fixed at 1 cycle; at most one read is in flight at a time (fifo_rd_en may re-assert on the capture cycle).
- Stream output:
  - m_valid = (buf_level != 0).
  - m_data = buffer[read index], a registered storage output.
  - Pop occurs on m_valid && m_ready.
  - Once m_valid=1, m_data is held stable and m_valid stays high until the word is accepted.
- Push/pop in the same cycle: buf_level unchanged; both indices advance.
- Indices:
  - $clog2(SKID_DEPTH) bits each; wrap naturally from SKID_DEPTH-1 to 0.
  - buf_level range is 0..SKID_DEPTH.
- Boundary conditions:
  - Buffer full (buf_level=SKID_DEPTH): no new read is issued. The credit rule guarantees a capture never overflows the buffer.
  - Buffer empty: m_valid=0; m_ready is ignored.
  - fifo_empty rising while a read is in flight: the in-flight word is still captured.
- Latency and throughput:
  - First word: 2 cycles from fifo_empty falling to m_valid=1 (issue cycle, capture edge).
  - With SKID_DEPTH≥3, m_ready held at 1 and the FIFO non-empty: sustained 1 word/cycle.
  - With SKID_DEPTH=2: 2 words per 3 cycles.
- Ordering: words leave in exactly the order they were read. No drop, no duplication.

Optional Feature:
- Macro RD_STREAM_CNT_EN.
- When defined, adds two ports:
  - cnt_clr  in  1  synchronous clear of the counter.
  - xfer_cnt  out  CNT_WIDTH  count of accepted stream handshakes.
- Counter rules:
  - Increments on each m_valid && m_ready; wraps modulo 2^CNT_WIDTH.
  - cnt_clr has priority: counter goes to 0 even if a handshake occurs that cycle.
  - Reset value is 0.
- When undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then idle, with fifo_empty=1 and m_ready=1 for 20 cycles → fifo_rd_en=0, m_valid=0, buf_level=0 throughout.
- FIFO holds 0xA0..0xA7, m_ready=1, SKID_DEPTH=4 → first m_valid 2 cycles after fifo_empty falls; then 8 consecutive m_valid cycles carrying 0xA0..0xA7 in order; no fifo_rd_en while fifo_empty=1.
- m_ready=0 with FIFO holding 10 words → exactly 4 reads issued; buf_level saturates at 4; m_data=first word held stable. Releasing m_ready drains all 10 words in order.
- Toggle m_ready 1/0 each cycle with a continuous source → no loss or duplication across index wrap (≥3 full buffer wraps); buf_level never exceeds 4.
- Assert rst_rd_n=0 in the cycle after fifo_rd_en=1 with buf_level=2 → all outputs go to 0 immediately; after release, the in-flight word is not captured and buf_level=0.
- RD_STREAM_CNT_EN defined, CNT_WIDTH=4 → 17 handshakes give xfer_cnt=1 (wrap); cnt_clr in the same cycle as a handshake gives xfer_cnt=0.
